// File: rtl/dsp_svf_multi_pkg.sv
// ---------------------------------------------------------------------------
// dsp_svf_multi_pkg
// Shared types and constants for the multi-channel state-variable filter:
// default fixed-point format, per-channel mode encodings, the sequencer
// state enum, and the saturation bounds used by the multiplier and adder.
// ---------------------------------------------------------------------------
package dsp_svf_multi_pkg;

    localparam int DEF_BITS = 16;
    localparam int DEF_FRAC = 12;
    localparam int DEF_CH   = 4;

    typedef enum logic [1:0] {
        MODE_LP    = 2'd0,
        MODE_HP    = 2'd1,
        MODE_BP    = 2'd2,
        MODE_NOTCH = 2'd3
    } mode_e;

    // One channel takes four steps (LPU, HPU, BPU, WR); DONE publishes the frame.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LPU  = 3'd1,
        S_HPU  = 3'd2,
        S_BPU  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_e;

    // Largest value representable in a signed word of the given width.
    function automatic int sat_max(input int bits);
        return (1 <<< (bits - 1)) - 1;
    endfunction

    // Smallest value representable in a signed word of the given width.
    function automatic int sat_min(input int bits);
        return -(1 <<< (bits - 1));
    endfunction

endpackage

// File: rtl/dsp_svf_multi_if.sv
// ---------------------------------------------------------------------------
// dsp_svf_multi_if
// Frame bus of the multi-channel state-variable filter.
//   in_valid/in_ready : frame handshake (source -> filter)
//   sig_in/cutoff/damp: CH packed signed words, channel k at [k*BITS +: BITS]
//   mode              : CH packed 2-bit mode codes, channel k at [k*2 +: 2]
//   sig_out           : CH packed signed filtered samples
//   out_valid         : one-cycle pulse, sig_out carries a new frame
//   overrun           : sticky, a frame was offered while the filter was busy
//   dbg_state         : sequencer state, for observation only
//
// Handshake: a frame transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on the filter's own state,
// never on in_valid. The source may raise or drop in_valid at will; a frame
// offered while in_ready is low is not taken and flags overrun. out_valid has
// no back-pressure: the sink must take sig_out while out_valid is high, and
// sig_out then holds until the next frame completes.
// ---------------------------------------------------------------------------
interface dsp_svf_multi_if #(
    parameter int BITS = 16,
    parameter int CH   = 4
);
    import dsp_svf_multi_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [CH*BITS-1:0]   sig_in;
    logic [CH*BITS-1:0]   cutoff;
    logic [CH*BITS-1:0]   damp;
    logic [CH*2-1:0]      mode;
    logic [CH*BITS-1:0]   sig_out;
    logic                 out_valid;
    logic                 overrun;
    state_e               dbg_state;

    modport master (
        output in_valid, sig_in, cutoff, damp, mode,
        input  in_ready, sig_out, out_valid, overrun, dbg_state
    );

    modport slave (
        input  in_valid, sig_in, cutoff, damp, mode,
        output in_ready, sig_out, out_valid, overrun, dbg_state
    );

endinterface

// File: rtl/dsp_mult.sv
// ---------------------------------------------------------------------------
// dsp_mult
// Fixed-point signed multiply: p = sat((a*b) >>> FRAC).
// The product is kept at full 2*BITS width before the arithmetic shift so no
// intermediate wrap can occur; the shifted result is clamped to BITS.
//   a_i, b_i : signed operands, BITS wide
//   p_o      : signed saturated product, BITS wide
// ---------------------------------------------------------------------------
module dsp_mult
    import dsp_svf_multi_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int FRAC = DEF_FRAC
) (
    input  logic signed [BITS-1:0] a_i,
    input  logic signed [BITS-1:0] b_i,
    output logic signed [BITS-1:0] p_o
);
    localparam int PW = 2 * BITS;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    assign prod    = PW'(a_i) * PW'(b_i);
    assign shifted = prod >>> FRAC;

    always_comb begin
        p_o = shifted[BITS-1:0];
        if (shifted > PW'(sat_max(BITS))) begin
            p_o = BITS'(sat_max(BITS));
        end else if (shifted < PW'(sat_min(BITS))) begin
            p_o = BITS'(sat_min(BITS));
        end
    end

endmodule

// File: rtl/dsp_sat_add.sv
// ---------------------------------------------------------------------------
// dsp_sat_add
// Saturating three-term adder: y = sat(a +/- b - c).
// The sum is formed in BITS+2 bits, enough for any combination of three
// BITS-wide operands, and clamped once at the end. sub_b_i negates b, which
// lets the high-pass step compute in - lp - q*bp with a single clamp.
//   a_i, b_i, c_i : signed operands, BITS wide
//   sub_b_i       : 1 subtracts b instead of adding it
//   y_o           : signed saturated result, BITS wide
// ---------------------------------------------------------------------------
module dsp_sat_add
    import dsp_svf_multi_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic signed [BITS-1:0] a_i,
    input  logic signed [BITS-1:0] b_i,
    input  logic signed [BITS-1:0] c_i,
    input  logic                   sub_b_i,
    output logic signed [BITS-1:0] y_o
);
    localparam int SW = BITS + 2;

    logic signed [SW-1:0] b_x;
    logic signed [SW-1:0] sum;

    assign b_x = sub_b_i ? -SW'(b_i) : SW'(b_i);
    assign sum = SW'(a_i) + b_x - SW'(c_i);

    always_comb begin
        y_o = sum[BITS-1:0];
        if (sum > SW'(sat_max(BITS))) begin
            y_o = BITS'(sat_max(BITS));
        end else if (sum < SW'(sat_min(BITS))) begin
            y_o = BITS'(sat_min(BITS));
        end
    end

endmodule

// File: rtl/dsp_svf_multi.sv
// ---------------------------------------------------------------------------
// dsp_svf_multi
// CH-channel Chamberlin state-variable filter with per-channel cutoff (f),
// damping (q) and output mode (LP/HP/BP/NOTCH). All channels share one
// multiplier and one saturating adder; a sequencer walks every channel
// through LPU -> HPU -> BPU -> WR and then publishes the frame in DONE.
//   clk : system clock
//   rst : synchronous, active-high reset; aborts any frame in progress
//   bus : frame bus (slave side), see dsp_svf_multi_if
// Latency: frame accepted at cycle 0, out_valid at cycle 4*CH+1, in_ready
// back at cycle 4*CH+2.
// ---------------------------------------------------------------------------
module dsp_svf_multi
    import dsp_svf_multi_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int FRAC = DEF_FRAC,
    parameter int CH   = DEF_CH
) (
    input  logic           clk,
    input  logic           rst,
    dsp_svf_multi_if.slave bus
);
    localparam int CW = $clog2(CH) + 1;
    // Array index width; a single-channel build still needs one bit.
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    typedef logic signed [BITS-1:0] smp_t;

    // Sequencer
    state_e         state_q, state_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [IW-1:0]  idx;
    logic           last_ch;
    logic           accept;

    // Captured frame
    smp_t           in_q   [CH];
    smp_t           f_q    [CH];
    smp_t           damp_q [CH];
    mode_e          mode_q [CH];

    // Filter state and working values of the channel in flight
    smp_t           lp_q [CH];
    smp_t           bp_q [CH];
    smp_t           lp_new_q;
    smp_t           hp_q;
    smp_t           bp_new_q;

    // Outputs collected per channel, published together
    smp_t               out_buf_q [CH];
    logic [CH*BITS-1:0] sig_out_q;
    logic [CH*BITS-1:0] sig_out_nxt;
    logic               overrun_q;

    // Shared arithmetic
    smp_t           mul_a, mul_b, mul_p;
    smp_t           add_a, add_b, add_c, add_y;
    logic           add_sub_b;
    smp_t           wr_val;

    assign idx     = ch_q[IW-1:0];
    assign last_ch = (ch_q == CW'(CH - 1));
    assign accept  = (state_q == S_IDLE) && bus.in_valid;

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_LPU;
                    ch_d    = '0;
                end
            end
            S_LPU:  state_d = S_HPU;
            S_HPU:  state_d = S_BPU;
            S_BPU:  state_d = S_WR;
            S_WR: begin
                if (last_ch) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LPU;
                    ch_d    = ch_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand steering for the shared multiplier and adder
    //   LPU: lp' = lp + f*bp
    //   HPU: hp  = in - lp' - q*bp
    //   BPU: bp' = bp + f*hp
    //   WR : notch = hp + lp' (adder is otherwise idle here)
    // -----------------------------------------------------------------------
    always_comb begin
        mul_a     = '0;
        mul_b     = '0;
        add_a     = '0;
        add_b     = '0;
        add_c     = '0;
        add_sub_b = 1'b0;
        case (state_q)
            S_LPU: begin
                mul_a = f_q[idx];
                mul_b = bp_q[idx];
                add_a = lp_q[idx];
                add_b = mul_p;
            end
            S_HPU: begin
                mul_a     = damp_q[idx];
                mul_b     = bp_q[idx];
                add_a     = in_q[idx];
                add_b     = lp_new_q;
                add_sub_b = 1'b1;
                add_c     = mul_p;
            end
            S_BPU: begin
                mul_a = f_q[idx];
                mul_b = hp_q;
                add_a = bp_q[idx];
                add_b = mul_p;
            end
            S_WR: begin
                add_a = hp_q;
                add_b = lp_new_q;
            end
            default: ;
        endcase
    end

    dsp_mult #(
        .BITS (BITS),
        .FRAC (FRAC)
    ) u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    dsp_sat_add #(
        .BITS (BITS)
    ) u_add (
        .a_i     (add_a),
        .b_i     (add_b),
        .c_i     (add_c),
        .sub_b_i (add_sub_b),
        .y_o     (add_y)
    );

    // Channel output selected by its mode; only meaningful in WR.
    always_comb begin
        wr_val = lp_new_q;
        case (mode_q[idx])
            MODE_LP:    wr_val = lp_new_q;
            MODE_HP:    wr_val = hp_q;
            MODE_BP:    wr_val = bp_new_q;
            MODE_NOTCH: wr_val = add_y;
            default:    wr_val = lp_new_q;
        endcase
    end

    // Full output word with the channel being written merged in, so the last
    // WR can load every channel into sig_out at once.
    always_comb begin
        sig_out_nxt = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == IW'(k)) begin
                sig_out_nxt[k*BITS +: BITS] = wr_val;
            end else begin
                sig_out_nxt[k*BITS +: BITS] = out_buf_q[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                in_q[k]      <= '0;
                f_q[k]       <= '0;
                damp_q[k]    <= '0;
                mode_q[k]    <= MODE_LP;
                lp_q[k]      <= '0;
                bp_q[k]      <= '0;
                out_buf_q[k] <= '0;
            end
            lp_new_q  <= '0;
            hp_q      <= '0;
            bp_new_q  <= '0;
            sig_out_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.in_valid && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (accept) begin
                for (int k = 0; k < CH; k++) begin
                    in_q[k]   <= bus.sig_in[k*BITS +: BITS];
                    f_q[k]    <= bus.cutoff[k*BITS +: BITS];
                    damp_q[k] <= bus.damp[k*BITS +: BITS];
                    mode_q[k] <= mode_e'(bus.mode[k*2 +: 2]);
                end
            end
            case (state_q)
                S_LPU: lp_new_q <= add_y;
                S_HPU: hp_q     <= add_y;
                S_BPU: bp_new_q <= add_y;
                S_WR: begin
                    lp_q[idx]      <= lp_new_q;
                    bp_q[idx]      <= bp_new_q;
                    out_buf_q[idx] <= wr_val;
                    if (last_ch) begin
                        sig_out_q <= sig_out_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sig_out   = sig_out_q;
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dsp_svf_multi.sv
// ---------------------------------------------------------------------------
// tb_dsp_svf_multi
// Drives a two-channel and a single-channel filter with directed and random
// frames and compares every published frame, plus handshake timing, against
// a behavioural model of the filter equations.
// ---------------------------------------------------------------------------
module tb_dsp_svf_multi;
    import dsp_svf_multi_pkg::*;

    localparam int BITS = 16;
    localparam int FRAC = 12;
    localparam int CH   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_svf_multi_if #(.BITS(BITS), .CH(CH)) bus ();
    dsp_svf_multi_if #(.BITS(BITS), .CH(1))  bus1 ();

    dsp_svf_multi #(.BITS(BITS), .FRAC(FRAC), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dsp_svf_multi #(.BITS(BITS), .FRAC(FRAC), .CH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus for the next frame (per channel) and observed outputs.
    int s_in [2];
    int s_f  [2];
    int s_q  [2];
    int s_m  [2];
    int obs  [2];

    // Model state: slots 0,1 for the two-channel DUT, slot 2 for the CH=1 DUT.
    int m_lp [3];
    int m_bp [3];
    int exp_q [$];

    // ---------------- reference model ----------------
    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int mulq(input int a, input int b);
        return sat16((longint'(a) * longint'(b)) >>> FRAC);
    endfunction

    // One filter update of a channel; returns the moded output.
    function automatic int model_ch(input int slot, input int x, input int f,
                                    input int q, input int m);
        int lp, hp, bp;
        lp = sat16(longint'(m_lp[slot]) + mulq(f, m_bp[slot]));
        hp = sat16(longint'(x) - lp - mulq(q, m_bp[slot]));
        bp = sat16(longint'(m_bp[slot]) + mulq(f, hp));
        m_lp[slot] = lp;
        m_bp[slot] = bp;
        case (m)
            0:       return lp;
            1:       return hp;
            2:       return bp;
            default: return sat16(longint'(hp) + lp);
        endcase
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ch(input int c, input int x, input int f, input int q, input int m);
        s_in[c] = x;
        s_f[c]  = f;
        s_q[c]  = q;
        s_m[c]  = m;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus1.in_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_lp[i] = 0;
            m_bp[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic drive_frame2();
        bus.in_valid = 1'b1;
        bus.sig_in   = {16'(s_in[1]), 16'(s_in[0])};
        bus.cutoff   = {16'(s_f[1]),  16'(s_f[0])};
        bus.damp     = {16'(s_q[1]),  16'(s_q[0])};
        bus.mode     = {2'(s_m[1]),   2'(s_m[0])};
    endtask

    // Full frame on the two-channel DUT, with timing and output checks.
    task automatic run_frame2(input string tag);
        int vld_at, vld_cnt, rdy_busy;
        int e [2];
        for (int c = 0; c < CH; c++) begin
            exp_q.push_back(model_ch(c, s_in[c], s_f[c], s_q[c], s_m[c]));
        end
        @(negedge clk);
        drive_frame2();
        check({tag, " ready_before"}, int'(bus.in_ready), 1);
        @(posedge clk);
        vld_at = -1; vld_cnt = 0; rdy_busy = 0;
        for (int k = 1; k <= 4*CH + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Inputs are don't-care once the frame is taken.
                bus.in_valid = 1'b0;
                bus.sig_in   = $urandom;
                bus.cutoff   = $urandom;
                bus.damp     = $urandom;
                bus.mode     = 4'($urandom);
            end
            if (bus.out_valid) begin
                vld_cnt++;
                if (vld_at < 0) begin
                    vld_at = k;
                    obs[0] = int'($signed(bus.sig_out[15:0]));
                    obs[1] = int'($signed(bus.sig_out[31:16]));
                end
            end
            if (k <= 4*CH + 1 && bus.in_ready) rdy_busy++;
            if (k == 4*CH + 2) check({tag, " ready_after"}, int'(bus.in_ready), 1);
        end
        check({tag, " out_valid_cycle"}, vld_at, 4*CH + 1);
        check({tag, " out_valid_width"}, vld_cnt, 1);
        check({tag, " ready_low_busy"}, rdy_busy, 0);
        for (int c = 0; c < CH; c++) begin
            e[c] = exp_q.pop_front();
            check($sformatf("%s out%0d", tag, c), obs[c], e[c]);
        end
        check({tag, " hold0"}, int'($signed(bus.sig_out[15:0])), e[0]);
    endtask

    // Full frame on the single-channel DUT (stimulus from slot 0).
    task automatic run_frame1(input string tag);
        int vld_at, vld_cnt, e;
        exp_q.push_back(model_ch(2, s_in[0], s_f[0], s_q[0], s_m[0]));
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.sig_in   = 16'(s_in[0]);
        bus1.cutoff   = 16'(s_f[0]);
        bus1.damp     = 16'(s_q[0]);
        bus1.mode     = 2'(s_m[0]);
        check({tag, " ready_before"}, int'(bus1.in_ready), 1);
        @(posedge clk);
        vld_at = -1; vld_cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus1.in_valid = 1'b0;
                bus1.sig_in   = 16'($urandom);
            end
            if (bus1.out_valid) begin
                vld_cnt++;
                if (vld_at < 0) begin
                    vld_at = k;
                    obs[0] = int'($signed(bus1.sig_out));
                end
            end
        end
        check({tag, " out_valid_cycle"}, vld_at, 5);
        check({tag, " out_valid_width"}, vld_cnt, 1);
        e = exp_q.pop_front();
        check({tag, " out0"}, obs[0], e);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int ov_cnt;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.sig_in = '0; bus.cutoff = '0; bus.damp = '0; bus.mode = '0;
        bus1.in_valid = 1'b0; bus1.sig_in = '0; bus1.cutoff = '0; bus1.damp = '0; bus1.mode = '0;

        // Reset values
        do_reset(3);
        check("rst sig_out", int'(bus.sig_out), 0);
        check("rst out_valid", int'(bus.out_valid), 0);
        check("rst in_ready", int'(bus.in_ready), 1);
        check("rst overrun", int'(bus.overrun), 0);
        check("rst state", int'(bus.dbg_state), int'(S_IDLE));
        check("rst ch1 sig_out", int'(bus1.sig_out), 0);
        check("rst ch1 in_ready", int'(bus1.in_ready), 1);

        // LP on DC input, two frames
        set_ch(0, 2048, 1024, 4096, int'(MODE_LP));
        set_ch(1, 0, 1024, 4096, int'(MODE_LP));
        run_frame2("lpdc f1");
        check("lpdc f1 const0", obs[0], 0);
        check("lpdc f1 const1", obs[1], 0);
        run_frame2("lpdc f2");
        check("lpdc f2 const0", obs[0], 128);
        check("lpdc f2 const1", obs[1], 0);

        // Saturation in HP mode
        do_reset(1);
        set_ch(0, 32767, 4096, 0, int'(MODE_HP));
        set_ch(1, 0, 0, 0, int'(MODE_LP));
        run_frame2("sat f1");
        check("sat f1 const0", obs[0], 32767);
        set_ch(0, -32768, 4096, 4096, int'(MODE_HP));
        run_frame2("sat f2");
        check("sat f2 const0", obs[0], -32768);

        // Overrun, then reset in the middle of a frame
        do_reset(1);
        set_ch(0, 2048, 1024, 4096, int'(MODE_LP));
        set_ch(1, 0, 1024, 4096, int'(MODE_LP));
        @(negedge clk);
        drive_frame2();
        @(posedge clk);                  // end of cycle 0: frame taken
        @(negedge clk); bus.in_valid = 1'b0;   // cycle 1
        @(negedge clk);                        // cycle 2
        @(negedge clk); bus.in_valid = 1'b1;   // cycle 3: offered while busy
        check("ovr before", int'(bus.overrun), 0);
        @(negedge clk); bus.in_valid = 1'b0;   // cycle 4
        check("ovr set", int'(bus.overrun), 1);
        @(negedge clk); rst = 1'b1;            // cycle 5
        @(negedge clk); rst = 1'b0;
        check("midrst overrun", int'(bus.overrun), 0);
        check("midrst in_ready", int'(bus.in_ready), 1);
        ov_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        check("midrst no out_valid", ov_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            m_lp[i] = 0;
            m_bp[i] = 0;
        end
        run_frame2("after rst f1");
        check("after rst f1 const0", obs[0], 0);
        run_frame2("after rst f2");
        check("after rst f2 const0", obs[0], 128);
        check("after rst overrun", int'(bus.overrun), 0);

        // Random frames, state carried across frames and mode changes
        for (int n = 0; n < 24; n++) begin
            for (int c = 0; c < CH; c++) begin
                set_ch(c, int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 4096)),
                       int'($urandom_range(0, 8192)),
                       int'($urandom_range(0, 3)));
            end
            run_frame2($sformatf("rnd%0d", n));
        end

        // Single-channel notch with zero coefficients passes input through
        set_ch(0, 1000, 0, 0, int'(MODE_NOTCH));
        for (int n = 0; n < 3; n++) begin
            run_frame1($sformatf("notch%0d", n));
            check($sformatf("notch%0d const", n), obs[0], 1000);
        end
        for (int n = 0; n < 6; n++) begin
            set_ch(0, int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 4096)),
                   int'($urandom_range(0, 8192)),
                   int'($urandom_range(0, 3)));
            run_frame1($sformatf("rnd1_%0d", n));
        end
        check("ch1 overrun", int'(bus1.overrun), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
